uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares a single uart_tx instance between N_REQ byte-stream requesters.
- Grants the transmitter round-robin and holds each grant for a whole message, up to MAX_BURST bytes.
- Drives the uart_tx write strobe and data byte, paced by the uart_tx empty (txe) and complete (txc) flags.
- Sits between the SoC's message sources (console, debug, status) and the uart_tx module.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).
- WAIT_TXC, 1, when 1, the grant is released only after the uart_tx complete pulse for the final byte; when 0, it is released once that byte is loaded.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  per-requester "byte available" level.
- i_data  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- i_last  in  N_REQ  the presented byte is the last byte of the message.
- o_gnt  out  N_REQ  one-hot grant (registered).
- o_ack  out  N_REQ  one-cycle pulse: the presented byte was taken.
- o_owner  out  3  index of the current or last grant.
- o_busy  out  1  state is not IDLE.
- o_tx_wr  out  1  write strobe to uart_tx (i_wr).
- o_tx_data  out  8  byte to uart_tx (i_data).
- i_tx_txe  in  1  uart_tx o_txe.
- i_tx_txc  in  1  uart_tx o_txc, a one-cycle pulse.

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE; all outputs 0; round-robin pointer 0; byte counter 0; o_tx_data 8'h00.
  - A reset mid-transfer drops o_tx_wr and o_gnt immediately.
  - A byte already loaded into uart_tx is not recalled.
- All outputs are registered. There is no combinational path from inputs to outputs.
- State IDLE:
  - If i_req is non-zero, the winner is the first set bit searching upward from the pointer, wrapping at N_REQ-1 to 0.
  - On a win: o_gnt is set to the one-hot winner, o_owner to the winner index, pointer to (winner+1) mod N_REQ, byte counter cleared; next state GRANT.
  - If i_req is zero, stay in IDLE.
- State GRANT (winner w):
  - If i_req[w]=1 and i_tx_txe=1: on the next edge set o_tx_wr=1, o_tx_data=i_data[w], o_ack[w]=1, byte counter +1, latch i_last[w]; next state SETTLE.
  - If i_req[w]=0: message abandoned; o_gnt is cleared and the state returns to IDLE. No byte is sent.
  - If i_req[w]=1 and i_tx_txe=0: wait.
- State SETTLE:
  - o_tx_wr and o_ack are high only during the first SETTLE cycle.
  - The state waits for i_tx_txe=0 while o_tx_wr=0. This guards against the registered txe still reading 1 just after the write.
  - Then, if the latched last=1 or the counter equals MAX_BURST: go to DRAIN if WAIT_TXC=1, else clear o_gnt and go to IDLE.
  - Otherwise return to GRANT.
- State DRAIN:
  - Hold o_gnt until i_tx_txc=1, then clear o_gnt and go to IDLE.
  - A txc pulse seen in any other state is ignored.
- Requester contract:
  - Hold i_data and i_last stable while i_req=1 and o_gnt is set, until o_ack.
  - Present the next byte within 1 cycle after o_ack.
- Fairness:
  - A forced release at MAX_BURST does not clear the requester's message.
  - The requester re-arbitrates and, with other requesters active, waits its round-robin turn.
- Rate and ordering:
  - At most one o_tx_wr per uart_tx empty period.
  - Back-to-back bytes from one owner never bypass SETTLE.
- Pointer updates only on a win. Abandon and forced release do not alter it.
- i_req bits of non-owners are ignored while busy.

Test Plan:
- Single requester 1 sends 3 bytes 8'h41, 8'h42, 8'h43 with i_last on 8'h43, WAIT_TXC=1:
  - Exactly 3 o_tx_wr pulses with data 41/42/43 in order, each after i_tx_txe=1.
  - o_gnt=4'b0010 held until the txc pulse after byte 43.
  - Then o_busy=0 and pointer=2.
- Requesters 0 and 2 both request single-byte messages continuously from reset:
  - Grant order 0, 2, 0, 2.
  - No two grants overlap.
  - o_owner tracks each grant.
- Requester 3 streams 20 bytes without i_last, MAX_BURST=16, requester 1 waiting:
  - Release after byte 16; requester 1 is granted next; requester 3 then resumes with byte 17.
- Requester 0 drops i_req in GRANT before any byte:
  - o_gnt clears the next cycle with no o_tx_wr.
  - Pointer stays at 1.
- i_rst_n asserted in SETTLE during a multi-byte message:
  - o_tx_wr, o_gnt and o_ack are 0 immediately.
  - After release, arbitration restarts from requester 0.
- WAIT_TXC=0 with the uart_tx model holding i_tx_txe=1 for 2 extra cycles after the write:
  - Only one o_tx_wr is issued per byte.
  - The grant is released immediately after the last byte's write settles.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the uart_tx flags and
// the uart_tx_arbiter. The arbiter connects through the slave modport.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   i_req;
    logic [8*N_REQ-1:0] i_data;
    logic [N_REQ-1:0]   i_last;
    logic [N_REQ-1:0]   o_gnt;
    logic [N_REQ-1:0]   o_ack;
    logic [2:0]         o_owner;
    logic               o_busy;
    logic               o_tx_wr;
    logic [7:0]         o_tx_data;
    logic               i_tx_txe;
    logic               i_tx_txc;

    modport slave (
        input  i_req, i_data, i_last, i_tx_txe, i_tx_txc,
        output o_gnt, o_ack, o_owner, o_busy, o_tx_wr, o_tx_data
    );

    modport master (
        output i_req, i_data, i_last, i_tx_txe, i_tx_txc,
        input  o_gnt, o_ack, o_owner, o_busy, o_tx_wr, o_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte-stream sources.
// A grant is held for a whole message (or MAX_BURST bytes); each byte goes
// through SETTLE so the transmitter's registered empty flag has dropped
// before the next byte can be offered.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int WAIT_TXC  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             tx_wr_q, tx_wr_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic             win_s;
    logic [2:0]       win_idx_s;
    int               off_s;
    int               best_s;
    logic             sel_req_s;
    logic             sel_last_s;
    logic [7:0]       sel_data_s;

    assign win_s = |bus.i_req;

    // Pick the first requester at or above the pointer, wrapping at N_REQ-1.
    always_comb begin
        win_idx_s = 3'd0;
        best_s    = N_REQ;
        off_s     = 0;
        for (int j = 0; j < N_REQ; j++) begin
            off_s = j - int'(ptr_q);
            if (off_s < 0) begin
                off_s = off_s + N_REQ;
            end else begin
                off_s = off_s;
            end
            if (bus.i_req[j] && (off_s < best_s)) begin
                best_s    = off_s;
                win_idx_s = 3'(j);
            end else begin
                best_s = best_s;
            end
        end
    end

    // Route the current owner's request, byte and last flag.
    always_comb begin
        sel_req_s  = 1'b0;
        sel_last_s = 1'b0;
        sel_data_s = 8'h00;
        for (int j = 0; j < N_REQ; j++) begin
            if (owner_q == 3'(j)) begin
                sel_req_s  = bus.i_req[j];
                sel_last_s = bus.i_last[j];
                sel_data_s = bus.i_data[8*j +: 8];
            end else begin
                sel_req_s = sel_req_s;
            end
        end
    end

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (win_s) begin
                    for (int j = 0; j < N_REQ; j++) begin
                        gnt_d[j] = (win_idx_s == 3'(j));
                    end
                    owner_d = win_idx_s;
                    ptr_d   = (win_idx_s == 3'(N_REQ - 1)) ? 3'd0 : (win_idx_s + 3'd1);
                    cnt_d   = 8'd0;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!sel_req_s) begin
                    // Message abandoned before the next byte: release, pointer untouched.
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (bus.i_tx_txe) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = sel_data_s;
                    ack_d     = gnt_q;
                    cnt_d     = cnt_q + 8'd1;
                    last_d    = sel_last_s;
                    state_d   = ST_SETTLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_SETTLE: begin
                // txe is registered in uart_tx, so it may still read 1 right after the write.
                if (tx_wr_q || bus.i_tx_txe) begin
                    state_d = ST_SETTLE;
                end else if (last_q || (cnt_q == 8'(MAX_BURST))) begin
                    if (WAIT_TXC != 0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_DRAIN: begin
                if (bus.i_tx_txc) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops the write strobe and grant at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            owner_q   <= 3'd0;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_ack     = ack_q;
    assign bus.o_owner   = owner_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_tx_wr   = tx_wr_q;
    assign bus.o_tx_data = tx_data_q;
endmodule
